// File: rtl/jp_cfg_serial.sv
// jp_cfg_serial: captures the USB-domain gamepad byte into the CPU clock
// domain and presents it to the 6502 via the $4016/$4017 strobe/serial-read
// protocol, standing in for a physical pad shift register.
//
// Ports:
//   clk_in        system clock
//   rst_in        asynchronous reset, active-high
//   cfg_in        button byte (A,B,Select,Start,Up,Down,Left,Right; bit0..7)
//   cfg_upd_in    asynchronous update strobe; cfg_in stable while high
//   a_in, d_in    CPU address / write data
//   wr_in, rd_in  one-cycle CPU write / read strobes
//   d_out         combinational read data, 8'h00 when not selected
//   btn_out       captured button byte
//   cfg_valid_out high once at least one update has been captured
module jp_cfg_serial #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter logic        FILL_BIT       = 1'b1,
    parameter bit          CFG_ACTIVE_LOW = 1'b0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [7:0]  cfg_in,
    input  logic        cfg_upd_in,
    input  logic [15:0] a_in,
    input  logic [7:0]  d_in,
    input  logic        wr_in,
    input  logic        rd_in,
    output logic [7:0]  d_out,
    output logic [7:0]  btn_out,
    output logic        cfg_valid_out
);

    localparam int unsigned BTN_W     = 8;
    localparam logic [15:0] ADDR_PAD1 = 16'h4016;
    localparam logic [15:0] ADDR_PAD2 = 16'h4017;
    // Upper bits of a pad read float to the high byte of the address ($40).
    localparam logic [6:0]  OPEN_BUS  = 7'b0100000;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   edge_q;
    logic                   upd_p;
    logic [BTN_W-1:0]       cfg_eff;
    logic [BTN_W-1:0]       btn_q;
    logic [BTN_W-1:0]       shift_q;
    logic                   strobe_q;
    logic                   valid_q;
    logic                   sel_pad1;
    logic                   sel_pad2;
    logic                   shift_en;
    logic                   serial_bit;
    logic                   unused_d;

    assign unused_d = ^d_in[7:1];

    // Synchronizer chain and edge history for the update strobe.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            sync_q <= '0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], cfg_upd_in};
            edge_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // One pulse per synchronized rising edge, so a held strobe captures once.
    assign upd_p   = sync_q[SYNC_STAGES-1] & ~edge_q;
    assign cfg_eff = CFG_ACTIVE_LOW ? ~cfg_in : cfg_in;

    // Button capture.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            btn_q   <= '0;
            valid_q <= 1'b0;
        end else if (upd_p) begin
            btn_q   <= cfg_eff;
            valid_q <= 1'b1;
        end
    end

    assign sel_pad1 = (a_in == ADDR_PAD1);
    assign sel_pad2 = (a_in == ADDR_PAD2);
    // A read coinciding with any write does not advance the shifter.
    assign shift_en = rd_in & sel_pad1 & ~wr_in & ~strobe_q;

    // Strobe latch.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            strobe_q <= 1'b0;
        end else if (wr_in && sel_pad1) begin
            strobe_q <= d_in[0];
        end
    end

    // Parallel load while strobed (uses pre-edge btn_q, so a same-edge
    // update lands on the next strobe), else shift toward bit 0 on reads.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            shift_q <= '0;
        end else if (strobe_q) begin
            shift_q <= btn_q;
        end else if (shift_en) begin
            shift_q <= {FILL_BIT, shift_q[BTN_W-1:1]};
        end
    end

    // While strobed the pad continuously reflects A, bypassing the load lag.
    assign serial_bit = strobe_q ? btn_q[0] : shift_q[0];

    // Read data mux.
    always_comb begin
        d_out = 8'h00;
        if (rd_in && sel_pad1) begin
            d_out = {OPEN_BUS, serial_bit};
        end else if (rd_in && sel_pad2) begin
            d_out = {OPEN_BUS, 1'b0};
        end
    end

    assign btn_out       = btn_q;
    assign cfg_valid_out = valid_q;

endmodule
